// File: rtl/cpu_decode_queue.sv
// Fetch-to-execute decode queue: toggle-tagged packet capture, DEPTH-entry FIFO, head immediate decode.
// Optional busy-cycle counter enabled by CPU_DECODE_QUEUE_STATS_EN.
module cpu_decode_queue #(
  parameter int DEPTH = 4
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic [120:0] i_data,
  output logic         o_busy,
  input  logic         i_flush,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [31:0]  o_instruction,
  output logic [31:0]  o_pc,
  output logic [5:0]   o_rs1,
  output logic [5:0]   o_rs2,
  output logic [5:0]   o_rs3,
  output logic [5:0]   o_rd,
  output logic [31:0]  o_imm,
  output logic         o_overflow,
  output logic [31:0]  o_stall_cycles
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_BUSY = (AW+1)'(DEPTH - 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rs3;
    logic [5:0]  rd;
  } entry_t;

  entry_t         r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic           r_last_tag;
  logic           r_overflow;

  entry_t         w_in;
  entry_t         w_head;
  logic           w_new;
  logic           w_pop;
  logic           w_push;
  logic [31:0]    w_ins;
  logic           w_unused_bits;

  assign w_in          = i_data[119:32];
  assign w_unused_bits = ^i_data[31:0];
  assign w_head        = r_mem[r_rptr];

  assign w_new   = (i_data[120] != r_last_tag);
  assign o_valid = (r_count != '0);
  assign w_pop   = o_valid && i_ready;
  // A full queue still accepts a packet when the head leaves on the same edge.
  assign w_push  = w_new && ((r_count != LP_FULL) || w_pop);
  assign o_busy  = (r_count >= LP_BUSY);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_last_tag <= 1'b0;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      // Adopt the presented tag so the packet on i_data is dropped, not replayed.
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_last_tag <= i_data[120];
    end else begin
      if (w_new) r_last_tag <= i_data[120];
      if (w_push) begin
        r_mem[r_wptr] <= w_in;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_new && !w_push) r_overflow <= 1'b1;
    end
  end

  assign o_instruction = w_head.instr;
  assign o_pc          = w_head.pc;
  assign o_rs1         = w_head.rs1;
  assign o_rs2         = w_head.rs2;
  assign o_rs3         = w_head.rs3;
  assign o_rd          = w_head.rd;
  assign o_overflow    = r_overflow;
  assign w_ins         = w_head.instr;

  always_comb begin
    o_imm = '0;
    case (w_ins[6:0])
      7'h03, 7'h07, 7'h13, 7'h67, 7'h73:
        o_imm = {{20{w_ins[31]}}, w_ins[31:20]};
      7'h23, 7'h27:
        o_imm = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
      7'h63:
        o_imm = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
      7'h17, 7'h37:
        o_imm = {w_ins[31:12], 12'b0};
      7'h6f:
        o_imm = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
      default:
        o_imm = '0;
    endcase
  end

`ifdef CPU_DECODE_QUEUE_STATS_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge i_clock) begin
    if (i_reset)     r_stall_cycles <= '0;
    else if (o_busy) r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign o_stall_cycles = r_stall_cycles;
`else
  assign o_stall_cycles = '0;
`endif

endmodule
